systolic_feeder: RTL and testbench

Upstream sequencer for the weight-stationary systolic array. It buffers one ROWS×COLS weight tile and shifts it down the top-row sum inputs with the load-weight line asserted. It then streams activation vectors into the row data inputs, skewed per row by the PE latency, and drains the array before accepting the next tile. It owns the row enable / load-weight lines and emits a skewed valid sideband for the downstream result collector.

---
 rtl/systolic_pkg.sv | 14 +
 rtl/systolic_skew_line.sv | 43 ++++
 rtl/systolic_feeder.sv | 179 +++++++++++++++++
 tb/tb_systolic_feeder.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared types for the systolic array, its feeder and the result collector.
package systolic_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_SHIFT,
        ST_STREAM,
        ST_DRAIN
    } feeder_state_t;

    localparam int DEF_PE_LATENCY = 4;

endpackage

// File: rtl/systolic_skew_line.sv
// Fixed-depth delay line for one activation lane plus its valid tag.
module systolic_skew_line #(
    parameter int DATAW = 32,
    parameter int DEPTH = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [DATAW-1:0] src_data,
    input  logic             src_valid,
    output logic [DATAW-1:0] dst_data,
    output logic             dst_valid
);

    generate
        if (DEPTH == 0) begin : g_pass
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ reset;
            assign dst_data  = src_data;
            assign dst_valid = src_valid;
        end else begin : g_line
            logic [DATAW-1:0] d_q [DEPTH];
            logic [DEPTH-1:0] v_q;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    for (int i = 0; i < DEPTH; i++) d_q[i] <= '0;
                    v_q <= '0;
                end else begin
                    d_q[0] <= src_data;
                    v_q[0] <= src_valid;
                    for (int i = 1; i < DEPTH; i++) begin
                        d_q[i] <= d_q[i-1];
                        v_q[i] <= v_q[i-1];
                    end
                end
            end

            assign dst_data  = d_q[DEPTH-1];
            assign dst_valid = v_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/systolic_feeder.sv
// Weight-tile loader and skewed activation streamer for the systolic array.
// Optional perf counters: define SYSTOLIC_FEEDER_PERF_EN.
module systolic_feeder
    import systolic_pkg::*;
#(
    parameter int DATA_SIZE  = 32,
    parameter int ROWS       = 4,
    parameter int COLS       = 4,
    parameter int PE_LATENCY = DEF_PE_LATENCY
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [COLS*DATA_SIZE-1:0] w_data,
    input  logic                      w_valid,
    output logic                      w_ready,
    input  logic [ROWS*DATA_SIZE-1:0] a_data,
    input  logic                      a_valid,
    output logic                      a_ready,
    input  logic                      a_last,
    output logic [ROWS*DATA_SIZE-1:0] row_data_out,
    output logic [COLS*DATA_SIZE-1:0] top_sum_out,
    output logic [ROWS-1:0]           row_enable_out,
    output logic [ROWS-1:0]           row_ld_weight_out,
    output logic [ROWS-1:0]           row_valid_out,
    output logic                      busy,
    output logic                      done
`ifdef SYSTOLIC_FEEDER_PERF_EN
    ,
    output logic [31:0]               perf_bubbles,
    output logic [31:0]               perf_busy
`endif
);

    localparam int WW        = COLS * DATA_SIZE;
    localparam int AW        = ROWS * DATA_SIZE;
    localparam int DRAIN_CYC = (ROWS + COLS) * PE_LATENCY;
    localparam int CW        = $clog2(DRAIN_CYC + ROWS + 1);

    feeder_state_t   state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [WW-1:0]   bank [ROWS];
    logic [AW-1:0]   inj_data;
    logic            inj_valid;
    logic            en, ld;
    logic            w_xfer, a_xfer;

    assign w_xfer = w_valid & w_ready;
    assign a_xfer = a_valid & a_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        w_ready     = 1'b0;
        a_ready     = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;
        en          = 1'b0;
        ld          = 1'b0;
        top_sum_out = '0;
        unique case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nxt = ST_FILL;
                    cnt_nxt   = '0;
                end
            end
            ST_FILL: begin
                w_ready = 1'b1;
                if (w_valid) begin
                    cnt_nxt = cnt + 1'b1;
                    if (cnt == CW'(ROWS - 1)) begin
                        state_nxt = ST_SHIFT;
                        cnt_nxt   = '0;
                    end
                end
            end
            ST_SHIFT: begin
                en = 1'b1;
                ld = 1'b1;
                // Deepest row's weight goes in first.
                for (int i = 0; i < ROWS; i++)
                    if (cnt == CW'(ROWS - 1 - i)) top_sum_out = bank[i];
                cnt_nxt = cnt + 1'b1;
                if (cnt == CW'(ROWS - 1)) begin
                    state_nxt = ST_STREAM;
                    cnt_nxt   = '0;
                end
            end
            ST_STREAM: begin
                a_ready = 1'b1;
                en      = 1'b1;
                if (a_valid && a_last) begin
                    state_nxt = ST_DRAIN;
                    cnt_nxt   = '0;
                end
            end
            ST_DRAIN: begin
                en      = 1'b1;
                cnt_nxt = cnt + 1'b1;
                if (cnt == CW'(DRAIN_CYC - 1)) begin
                    done      = 1'b1;
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign row_enable_out    = {ROWS{en}};
    assign row_ld_weight_out = {ROWS{ld}};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < ROWS; i++) bank[i] <= '0;
        end else if (w_xfer) begin
            for (int i = 0; i < ROWS; i++)
                if (cnt == CW'(i)) bank[i] <= w_data;
        end
    end

    // Idle cycles in STREAM and all of DRAIN inject zero bubbles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            inj_data  <= '0;
            inj_valid <= 1'b0;
        end else begin
            inj_data  <= a_xfer ? a_data : '0;
            inj_valid <= a_xfer;
        end
    end

    genvar r;
    generate
        for (r = 0; r < ROWS; r++) begin : g_row
            systolic_skew_line #(
                .DATAW (DATA_SIZE),
                .DEPTH (r * PE_LATENCY)
            ) u_skew (
                .clk       (clk),
                .reset     (reset),
                .src_data  (inj_data[r*DATA_SIZE +: DATA_SIZE]),
                .src_valid (inj_valid),
                .dst_data  (row_data_out[r*DATA_SIZE +: DATA_SIZE]),
                .dst_valid (row_valid_out[r])
            );
        end
    endgenerate

`ifdef SYSTOLIC_FEEDER_PERF_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_bubbles <= '0;
            perf_busy    <= '0;
        end else if (state == ST_IDLE && start) begin
            perf_bubbles <= '0;
            perf_busy    <= '0;
        end else begin
            if (busy && perf_busy != '1)
                perf_busy <= perf_busy + 1'b1;
            if (state == ST_STREAM && !a_valid && perf_bubbles != '1)
                perf_bubbles <= perf_bubbles + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_systolic_feeder.sv
// Randomized self-checking bench for systolic_feeder against a timeline model.
module tb_systolic_feeder;

    localparam int DW   = 32;
    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int PE   = 4;
    localparam int WW   = COLS * DW;
    localparam int AW   = ROWS * DW;
    localparam int DRN  = (ROWS + COLS) * PE;
    localparam int HN   = 4096;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [WW-1:0] w_data;
    logic          w_valid;
    logic          w_ready;
    logic [AW-1:0] a_data;
    logic          a_valid;
    logic          a_ready;
    logic          a_last;
    logic [AW-1:0] row_data_out;
    logic [WW-1:0] top_sum_out;
    logic [ROWS-1:0] row_enable_out;
    logic [ROWS-1:0] row_ld_weight_out;
    logic [ROWS-1:0] row_valid_out;
    logic          busy;
    logic          done;
`ifdef SYSTOLIC_FEEDER_PERF_EN
    logic [31:0]   perf_bubbles;
    logic [31:0]   perf_busy;
`endif

    systolic_feeder #(
        .DATA_SIZE  (DW),
        .ROWS       (ROWS),
        .COLS       (COLS),
        .PE_LATENCY (PE)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .w_data            (w_data),
        .w_valid           (w_valid),
        .w_ready           (w_ready),
        .a_data            (a_data),
        .a_valid           (a_valid),
        .a_ready           (a_ready),
        .a_last            (a_last),
        .row_data_out      (row_data_out),
        .top_sum_out       (top_sum_out),
        .row_enable_out    (row_enable_out),
        .row_ld_weight_out (row_ld_weight_out),
        .row_valid_out     (row_valid_out),
        .busy              (busy),
        .done              (done)
`ifdef SYSTOLIC_FEEDER_PERF_EN
        ,
        .perf_bubbles      (perf_bubbles),
        .perf_busy         (perf_busy)
`endif
    );

    always #5 clk = ~clk;

    int            n_cmp = 0;
    int            n_err = 0;
    int            cyc   = 0;
    int            busy_cnt;
    int            bub_cnt;
    logic [AW-1:0] hist_d [HN];
    bit            hist_v [HN];
    logic [WW-1:0] wbank  [ROWS];

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    task automatic clear_hist();
        for (int i = 0; i < HN; i++) begin
            hist_d[i] = '0;
            hist_v[i] = 1'b0;
        end
    endtask

    // Lane r accepted at edge e appears right after edge e + r*PE.
    task automatic check_rows();
        logic [AW-1:0]   ed;
        logic [ROWS-1:0] ev;
        ed = '0;
        ev = '0;
        for (int r = 0; r < ROWS; r++) begin
            int idx;
            idx = cyc - r * PE;
            if (idx >= 0 && idx < HN) begin
                ed[r*DW +: DW] = hist_d[idx][r*DW +: DW];
                ev[r]          = hist_v[idx];
            end
        end
        chk("row_data", 128'(row_data_out), 128'(ed));
        chk("row_valid", 128'(row_valid_out), 128'(ev));
    endtask

    // ph: 0 idle, 1 fill, 2 shift, 3 stream, 4 drain (expected after this edge)
    task automatic step(input int ph, input bit edone, input logic [WW-1:0] etop);
        @(posedge clk);
        #1;
        cyc++;
        if (ph != 0) busy_cnt++;
        chk("busy", 128'(busy), 128'(ph != 0));
        chk("w_ready", 128'(w_ready), 128'(ph == 1));
        chk("a_ready", 128'(a_ready), 128'(ph == 3));
        chk("enable", 128'(row_enable_out), 128'((ph >= 2) ? 4'hF : 4'h0));
        chk("ld_weight", 128'(row_ld_weight_out), 128'((ph == 2) ? 4'hF : 4'h0));
        chk("done", 128'(done), 128'(edone));
        chk("top_sum", 128'(top_sum_out), 128'(etop));
        check_rows();
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_busy"}, 128'(busy), 128'(0));
        chk({tag, "_w_ready"}, 128'(w_ready), 128'(0));
        chk({tag, "_a_ready"}, 128'(a_ready), 128'(0));
        chk({tag, "_enable"}, 128'(row_enable_out), 128'(0));
        chk({tag, "_ld"}, 128'(row_ld_weight_out), 128'(0));
        chk({tag, "_valid"}, 128'(row_valid_out), 128'(0));
        chk({tag, "_data"}, 128'(row_data_out), 128'(0));
        chk({tag, "_top"}, 128'(top_sum_out), 128'(0));
        chk({tag, "_done"}, 128'(done), 128'(0));
`ifdef SYSTOLIC_FEEDER_PERF_EN
        chk({tag, "_pbub"}, 128'(perf_bubbles), 128'(0));
        chk({tag, "_pbusy"}, 128'(perf_busy), 128'(0));
`endif
    endtask

    task automatic run_tile(input int nvec, input bit directed,
                            input bit start_mid, input int reset_at);
        int wi, k, vi, bub;
        logic [WW-1:0] nxt_top;
        busy_cnt = 0;
        bub_cnt  = 0;
        start = 1'b1;
        step(1, 1'b0, '0);
        start = 1'b0;

        wi = 0;
        k  = 0;
        while (wi < ROWS) begin
            if (directed) w_valid = (k % 2) == 1;
            else          w_valid = (k > 6) || ($urandom_range(0, 1) == 1);
            if (directed) w_data = WW'(10 * (wi + 1));
            else          w_data = {$urandom, $urandom, $urandom, $urandom};
            if (w_valid) begin
                wbank[wi] = w_data;
                wi++;
            end
            if (wi == ROWS) step(2, 1'b0, wbank[ROWS-1]);
            else            step(1, 1'b0, '0);
            k++;
        end
        w_valid = 1'b0;
        for (int s = 1; s < ROWS; s++) begin
            nxt_top = wbank[ROWS-1-s];
            step(2, 1'b0, nxt_top);
        end
        step(3, 1'b0, '0);

        vi  = 0;
        k   = 0;
        bub = 0;
        while (vi < nvec) begin
            if (directed && vi == 2 && bub < 3) begin
                a_valid = 1'b0;
                bub++;
            end else if (directed || k > 6) begin
                a_valid = 1'b1;
            end else begin
                a_valid = $urandom_range(0, 3) != 0;
            end
            start = start_mid && (k == 1);
            if (directed && vi == 0) a_data = {32'd4, 32'd3, 32'd2, 32'd1};
            else                     a_data = {$urandom, $urandom, $urandom, $urandom};
            a_last = a_valid && (vi == nvec - 1);
            if (a_valid) begin
                hist_d[cyc+1] = a_data;
                hist_v[cyc+1] = 1'b1;
                vi++;
                k = 0;
            end else begin
                bub_cnt++;
                k++;
            end
            step(a_last ? 4 : 3, 1'b0, '0);
            start = 1'b0;
            if (reset_at > 0 && vi == reset_at) begin
                a_valid = 1'b0;
                a_last  = 1'b0;
                reset   = 1'b0;
                #1;
                check_zero("rst_async");
                @(posedge clk);
                #1;
                check_zero("rst_hold");
                reset = 1'b1;
                clear_hist();
                step(0, 1'b0, '0);
                return;
            end
        end
        a_valid = 1'b0;
        a_last  = 1'b0;

        for (int d = 2; d <= DRN; d++) step(4, d == DRN, '0);
        step(0, 1'b0, '0);
        busy_cnt--;
`ifdef SYSTOLIC_FEEDER_PERF_EN
        chk("perf_bubbles", 128'(perf_bubbles), 128'(bub_cnt));
        chk("perf_busy", 128'(perf_busy), 128'(busy_cnt + 1));
`endif
        if (directed) chk("bubble_count", 128'(bub_cnt), 128'(3));
    endtask

    initial begin
        reset   = 1'b0;
        start   = 1'b0;
        w_data  = '0;
        w_valid = 1'b0;
        a_data  = '0;
        a_valid = 1'b0;
        a_last  = 1'b0;
        clear_hist();
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        reset = 1'b1;
        step(0, 1'b0, '0);

        run_tile(5, 1'b1, 1'b0, 0);
        run_tile($urandom_range(1, 8), 1'b0, 1'b1, 0);
        run_tile(8, 1'b0, 1'b0, 3);
        for (int t = 0; t < 3; t++)
            run_tile($urandom_range(1, 10), 1'b0, t == 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

endmodule
